// File: rtl/present80_enc_core_pkg.sv
// Shared definitions for the PRESENT-80 encryption core: widths, round limit,
// the 4-bit S-box table and the controller state type.
package present80_enc_core_pkg;

    localparam int BLOCK_W    = 64;
    localparam int KEY_W      = 80;
    localparam int CTR_W      = 5;
    localparam int ROUND_LAST = 31;

    // Entry n of the S-box sits in nibble n (bits [4n+3:4n]).
    localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_state_e;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present80_enc_core_sbox4.sv
// Single PRESENT 4-bit S-box, shared by the datapath and the key schedule.
module present80_enc_core_sbox4
    import present80_enc_core_pkg::*;
(
    input  logic [3:0] din_i,
    output logic [3:0] dout_o
);

    assign dout_o = sbox_lookup(din_i);

endmodule

// File: rtl/present80_enc_core_sbox_layer.sv
// PRESENT substitution layer: the 4-bit S-box applied to all 16 nibbles.
module present80_enc_core_sbox_layer
    import present80_enc_core_pkg::*;
(
    input  logic [BLOCK_W-1:0] din_i,
    output logic [BLOCK_W-1:0] dout_o
);

    for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_nib
        present80_enc_core_sbox4 u_sbox (
            .din_i  (din_i[4*n +: 4]),
            .dout_o (dout_o[4*n +: 4])
        );
    end

endmodule

// File: rtl/present_key_sched80.sv
// Combinational PRESENT-80 key update: rotate left by 61, S-box the top
// nibble, then fold the round counter into bits [19:15].
module present_key_sched80
    import present80_enc_core_pkg::*;
(
    input  logic [KEY_W-1:0] key_in,
    input  logic [CTR_W-1:0] round_ctr,
    output logic [KEY_W-1:0] key_out
);

    logic [KEY_W-1:0] rot;
    logic [3:0]       top_sbox;

    // Rotating left by 61 on an 80-bit word is the same as rotating right by 19.
    assign rot = {key_in[18:0], key_in[79:19]};

    present80_enc_core_sbox4 u_sbox (
        .din_i  (rot[79:76]),
        .dout_o (top_sbox)
    );

    assign key_out = {top_sbox, rot[75:20], rot[19:15] ^ round_ctr, rot[14:0]};

endmodule

// File: rtl/present80_enc_core.sv
// Iterative PRESENT-80 encryption core: one round per clock, 31 clocks per block.
// Handshake: start is honoured only while busy=0; done pulses one cycle as ciphertext updates.
module present80_enc_core
    import present80_enc_core_pkg::*;
#(
    parameter int NUM_ROUNDS = ROUND_LAST
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [KEY_W-1:0]   key,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] ciphertext,
    output fsm_state_e         dbg_state
);

    localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(NUM_ROUNDS);

    fsm_state_e         fsm_q;
    logic [BLOCK_W-1:0] state_q;
    logic [KEY_W-1:0]   key_q;
    logic [CTR_W-1:0]   ctr_q;
    logic [BLOCK_W-1:0] ct_q;
    logic               busy_q;
    logic               done_q;

    logic [BLOCK_W-1:0] sbox_in;
    logic [BLOCK_W-1:0] sbox_out;
    logic [BLOCK_W-1:0] state_d;
    logic [KEY_W-1:0]   key_d;

    assign sbox_in = state_q ^ key_q[79:16];

    present80_enc_core_sbox_layer u_sbox_layer (
        .din_i  (sbox_in),
        .dout_o (sbox_out)
    );

    // Permutation layer: bit i lands at 16*i mod 63, bit 63 is fixed.
    for (genvar i = 0; i < BLOCK_W - 1; i++) begin : g_perm
        assign state_d[(16 * i) % 63] = sbox_out[i];
    end
    assign state_d[63] = sbox_out[63];

    present_key_sched80 u_key_sched (
        .key_in    (key_q),
        .round_ctr (ctr_q),
        .key_out   (key_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            key_q   <= '0;
            ctr_q   <= '0;
            ct_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= plaintext;
                        key_q   <= key;
                        ctr_q   <= CTR_W'(1);
                        busy_q  <= 1'b1;
                        fsm_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    state_q <= state_d;
                    key_q   <= key_d;
                    // Last round folds in the final whitening key; the counter
                    // is parked at zero rather than wrapping past 31.
                    if (ctr_q == LAST_CTR) begin
                        ct_q   <= state_d ^ key_d[79:16];
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        ctr_q  <= '0;
                        fsm_q  <= S_IDLE;
                    end else begin
                        ctr_q <= ctr_q + CTR_W'(1);
                    end
                end
                default: begin
                    fsm_q  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ciphertext = ct_q;
    assign dbg_state  = fsm_q;

endmodule

// File: tb/tb_present80_enc_core.sv
// Scoreboard bench for present80_enc_core: known-answer vectors, busy/start
// interaction, mid-run reset and random blocks against a behavioural model.
module tb_present80_enc_core;
    import present80_enc_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] plaintext = '0;
    logic [79:0] key = '0;
    logic        busy;
    logic        done;
    logic [63:0] ciphertext;
    fsm_state_e  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    int sbox_tbl[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    present80_enc_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k);
        logic [63:0] s;
        logic [63:0] p;
        logic [79:0] kk;
        s  = pt;
        kk = k;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sbox_tbl[s[4*n +: 4]]);
            p = '0;
            for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16 * i) % 63] = s[i];
            s  = p;
            kk = (kk << 61) | (kk >> 19);
            kk[79:76] = 4'(sbox_tbl[kk[79:76]]);
            kk[19:15] = kk[19:15] ^ 5'(r);
        end
        return s ^ kk[79:16];
    endfunction

    // ---------------- check helper ----------------
    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called in the phase just after a rising edge; returns one edge after acceptance.
    task automatic send(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] exp);
        int n;
        logic [95:0] junk;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (busy) begin
            n_fail++;
            $display("FAIL send_wait: busy stuck got 1 expected 0");
            return;
        end
        plaintext = pt;
        key       = k;
        start     = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start     = 1'b0;
        junk      = {$urandom(), $urandom(), $urandom()};
        plaintext = junk[63:0];
        key       = junk[95:16];
    endtask

    task automatic send_rand();
        logic [95:0] r;
        logic [63:0] pt;
        logic [79:0] k;
        r  = {$urandom(), $urandom(), $urandom()};
        k  = r[79:0];
        pt = {$urandom(), $urandom()};
        send(pt, k, ref_enc(pt, k));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_done: done got 0 expected 1 within 60 cycles");
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        done_prev = 1'b0;
    logic        busy_prev = 1'b0;
    int          busy_cnt  = 0;
    logic [63:0] last_ct   = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (done) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: ct got %h expected no done", ciphertext);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    n_tests--;
                    check64("ciphertext", ciphertext, e);
                end
                n_tests++;
                if (done_prev) begin
                    n_fail++;
                    $display("FAIL done_width: done got 2+ cycles expected 1");
                end
            end else if (ciphertext !== last_ct) begin
                n_tests++;
                n_fail++;
                $display("FAIL ct_stable: ct got %h expected %h", ciphertext, last_ct);
            end
            if (busy) begin
                busy_cnt++;
            end else if (busy_prev) begin
                n_tests++;
                if (busy_cnt != 31) begin
                    n_fail++;
                    $display("FAIL busy_len: got %0d expected 31", busy_cnt);
                end
                n_tests++;
                if (!done) begin
                    n_fail++;
                    $display("FAIL done_at_end: done got 0 expected 1 as busy falls");
                end
                busy_cnt = 0;
            end
        end
        done_prev = done;
        busy_prev = busy;
        last_ct   = ciphertext;
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_busy", 64'(busy), 64'd0);
        check64("reset_done", 64'(done), 64'd0);
        check64("reset_ct", ciphertext, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // known-answer vectors
        send(64'h0, 80'h0, 64'h5579C1387B228445);
        send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
        send({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
        send({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);

        // starts while busy are ignored; a start in the done cycle is taken
        send(64'h0123456789ABCDEF, 80'h00112233445566778899,
             ref_enc(64'h0123456789ABCDEF, 80'h00112233445566778899));
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; plaintext = '1; key = '1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        send(64'hFEDCBA9876543210, 80'hA5A5A5A5A5A5A5A5A5A5,
             ref_enc(64'hFEDCBA9876543210, 80'hA5A5A5A5A5A5A5A5A5A5));
        wait_done();
        @(posedge clk); #1;

        // reset in the middle of a block aborts it
        send(64'hDEADBEEFCAFEF00D, 80'h13579BDF02468ACE1357,
             ref_enc(64'hDEADBEEFCAFEF00D, 80'h13579BDF02468ACE1357));
        repeat (14) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
        check64("abort_busy", 64'(busy), 64'd0);
        check64("abort_done", 64'(done), 64'd0);
        check64("abort_ct", ciphertext, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(64'h0, 80'h0, 64'h5579C1387B228445);

        // random back-to-back blocks
        for (int i = 0; i < 1000; i++) send_rand();

        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check64("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/present80_enc_core.md
PRESENT80_ENC_CORE -- requirements
Module: present80_enc_core

Interface
REQ-001 Parameter: NUM_ROUNDS, default 31, number of full rounds (addRoundKey+sBoxLayer+pLayer) before final key whitening; only the value 31 is supported.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to encrypt; sampled only when busy=0.
REQ-005 plaintext  input  64  block to encrypt; sampled on the accepted start edge.
REQ-006 key  input  80  PRESENT-80 user key; sampled on the accepted start edge.
REQ-007 busy  output  1  high while an encryption is in progress.
REQ-008 done  output  1  single-cycle pulse marking ciphertext valid.
REQ-009 ciphertext  output  64  result; held stable until the next completion.

Function
REQ-010 The FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-011 In IDLE, start=1 at edge T0 SHALL load state_reg<=plaintext, key_reg<=key, round_ctr<=1, and move to RUN.
REQ-012 At each RUN edge, the core SHALL compute state_reg<=pLayer(sBoxLayer(state_reg ^ key_reg[79:16])) and key_reg<=update(key_reg, round_ctr), then increment round_ctr.
REQ-013 sBoxLayer SHALL apply the PRESENT 4-bit S-box (C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2) to all 16 nibbles.
REQ-014 pLayer SHALL move bit i to bit (16*i mod 63) for i=0..62; bit 63 SHALL stay at bit 63.
REQ-015 Key update: rotate key_reg left by 61; pass bits [79:76] through the S-box; XOR bits [19:15] with the 5-bit round_ctr.
REQ-016 The edge that processes round_ctr=31 (T31) SHALL set ciphertext<=next_state ^ next_key[79:16], pulse done for one cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: start accepted at T0 -> done high in the cycle following T31 (31 clocks); throughput one block per 31 clocks with back-to-back starts.
REQ-018 start while busy=1 SHALL be ignored without side effects.
REQ-019 start in the cycle in which done is high SHALL be accepted, because the FSM is already IDLE then.
REQ-020 plaintext and key SHALL be don't-care outside the accepted start edge.
REQ-021 ciphertext SHALL NOT change except at a completion edge or on reset.
REQ-022 round_ctr SHALL be 5 bits and SHALL never wrap inside an encryption.

Reset
REQ-023 When rst_n=0, the core SHALL go to IDLE and clear busy=0, done=0, ciphertext=0, state_reg=0, key_reg=0 and round_ctr=0.
REQ-024 Reset asserted mid-encryption SHALL abort the encryption with no done pulse; the first start after release SHALL run normally.
REQ-025 Reset release SHALL be synchronised externally; the core asserts reset asynchronously only.

Structure
REQ-026 A shared package SHALL hold the S-box table, the FSM state enum, the constants ROUND_LAST=31 and the widths 64/80.
REQ-027 The datapath S-box layer SHALL reuse the existing 16-nibble S-box layer module.
REQ-028 The key schedule SHALL be a sub-module present_key_sched80 (combinational: key_in, round_ctr -> key_out), reusing the existing 4-bit S-box module.
REQ-029 The pLayer SHALL be pure wiring, with no logic.

Verification
REQ-030 Reset, then pt=0000000000000000, key=0x00000000000000000000, start -> done after 31 clocks, ciphertext=5579C1387B228445.
REQ-031 pt=0000000000000000, key=0xFFFFFFFFFFFFFFFFFFFF -> ciphertext=E72C46C0F5945049.
REQ-032 pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B; pt=FFFFFFFFFFFFFFFF, key=all-ones -> 3333DCD3213210D2.
REQ-033 start pulsed at cycles 5 and 20 of a running encryption -> exactly one done, result unchanged; then start in the done cycle -> second result after 31 more clocks.
REQ-034 rst_n low at round 15 -> busy=0, ciphertext=0, no done; a restart with vector REQ-030 -> 5579C1387B228445.
REQ-035 Random pt/key (>=1000 vectors) against a reference model -> ciphertext match, done width exactly 1 cycle, busy high exactly 31 cycles per block.
